// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 8x16 register file: ALU and load writebacks share one
// registered write stage, with a per-register busy scoreboard. Define WB_STARVE_EN for the ALU anti-starvation override.
module regfile_write_arbiter #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 3,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     AluValid,
   input  logic [ADDR_W-1:0]        AluRD,
   input  logic [DATA_W-1:0]        AluData,
   output logic                     AluReady,
   input  logic                     MemValid,
   input  logic [ADDR_W-1:0]        MemRD,
   input  logic [DATA_W-1:0]        MemData,
   output logic                     MemReady,
   input  logic                     IssueValid,
   input  logic [ADDR_W-1:0]        IssueRD,
   output logic                     IssueStall,
   output logic [(1<<ADDR_W)-1:0]   Busy,
   output logic                     RegWrite,
   output logic [ADDR_W-1:0]        RD,
   output logic [DATA_W-1:0]        WriteData
);

   localparam int NREGS = 1 << ADDR_W;

   logic             alu_ready_s;
   logic             mem_ready_s;
   logic             starve_force_s;
   logic [NREGS-1:0] clr_mask_s;
   logic [NREGS-1:0] set_mask_s;
   logic [NREGS-1:0] busy_next_s;

`ifdef WB_STARVE_EN
   logic [1:0] starve_cnt_r;

   // Counts consecutive cycles in which a pending ALU request lost arbitration
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         starve_cnt_r <= 2'd0;
      end else if (!AluValid || alu_ready_s) begin
         starve_cnt_r <= 2'd0;
      end else begin
         starve_cnt_r <= starve_cnt_r + 2'd1;
      end
   end

   assign starve_force_s = (starve_cnt_r == 2'(STARVE_LIMIT)) && AluValid && MemValid;
`else
   assign starve_force_s = 1'b0;
`endif

   // Grant selection: loads have fixed priority unless the ALU is being rescued
   always_comb begin
      alu_ready_s = 1'b0;
      mem_ready_s = 1'b0;
      if (Reset) begin
         alu_ready_s = 1'b0;
         mem_ready_s = 1'b0;
      end else if (MemValid && !starve_force_s) begin
         mem_ready_s = 1'b1;
      end else if (AluValid) begin
         alu_ready_s = 1'b1;
      end else begin
         alu_ready_s = 1'b0;
      end
   end

   assign AluReady   = alu_ready_s;
   assign MemReady   = mem_ready_s;
   assign IssueStall = IssueValid && Busy[IssueRD] && !Reset;

   // Registered write stage; address and data hold while idle
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         RegWrite  <= 1'b0;
         RD        <= '0;
         WriteData <= '0;
      end else if (mem_ready_s) begin
         RegWrite  <= 1'b1;
         RD        <= MemRD;
         WriteData <= MemData;
      end else if (alu_ready_s) begin
         RegWrite  <= 1'b1;
         RD        <= AluRD;
         WriteData <= AluData;
      end else begin
         RegWrite  <= 1'b0;
      end
   end

   // Scoreboard update; a reservation on the register being retired survives the clear
   always_comb begin
      clr_mask_s = '0;
      set_mask_s = '0;
      if (RegWrite) begin
         clr_mask_s[RD] = 1'b1;
      end else begin
         clr_mask_s = '0;
      end
      if (IssueValid && (!Busy[IssueRD] || clr_mask_s[IssueRD])) begin
         set_mask_s[IssueRD] = 1'b1;
      end else begin
         set_mask_s = '0;
      end
      busy_next_s = (Busy & ~clr_mask_s) | set_mask_s;
   end

   // Busy scoreboard register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Busy <= '0;
      end else begin
         Busy <= busy_next_s;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a behavioural model
// of the arbitration and scoreboard rules.
module tb_regfile_write_arbiter;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int NR = 8;
`ifdef WB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic          Clock = 1'b0;
   logic          Reset;
   logic          AluValid, MemValid, IssueValid;
   logic [AW-1:0] AluRD, MemRD, IssueRD;
   logic [DW-1:0] AluData, MemData;
   logic          AluReady, MemReady, IssueStall, RegWrite;
   logic [NR-1:0] Busy;
   logic [AW-1:0] RD;
   logic [DW-1:0] WriteData;

   regfile_write_arbiter dut (
      .Clock(Clock), .Reset(Reset),
      .AluValid(AluValid), .AluRD(AluRD), .AluData(AluData), .AluReady(AluReady),
      .MemValid(MemValid), .MemRD(MemRD), .MemData(MemData), .MemReady(MemReady),
      .IssueValid(IssueValid), .IssueRD(IssueRD), .IssueStall(IssueStall),
      .Busy(Busy), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit m_busy[NR];
   bit m_we;
   int m_rd;
   int m_wd;
   int m_starve;
   bit exp_ag, exp_mg;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NR-1:0] model_busy();
      logic [NR-1:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_we = 1'b0; m_rd = 0; m_wd = 0; m_starve = 0;
   endtask

   // one clock cycle: inputs must already be stable (driven after a negedge)
   task automatic step();
      bit force_alu;
      #1;
      force_alu = STARVE_EN && (m_starve >= 3) && AluValid && MemValid;
      exp_mg = MemValid && !force_alu;
      exp_ag = AluValid && (!MemValid || force_alu);
      check_val("alu_ready", AluReady, exp_ag);
      check_val("mem_ready", MemReady, exp_mg);
      check_val("issue_stall", IssueStall, IssueValid && m_busy[IssueRD]);
      @(posedge Clock);
      // retire the write presented this cycle, then take any reservation
      if (m_we) m_busy[m_rd] = 1'b0;
      if (IssueValid && !m_busy[IssueRD]) m_busy[IssueRD] = 1'b1;
      if (exp_mg) begin
         m_we = 1'b1; m_rd = MemRD; m_wd = MemData;
      end else if (exp_ag) begin
         m_we = 1'b1; m_rd = AluRD; m_wd = AluData;
      end else begin
         m_we = 1'b0;
      end
      m_starve = (!AluValid || exp_ag) ? 0 : m_starve + 1;
      #1;
      check_val("reg_write", RegWrite, m_we);
      check_val("rd", RD, m_rd);
      check_val("write_data", WriteData, m_wd);
      check_val("busy", Busy, model_busy());
      @(negedge Clock);
   endtask

   task automatic idle_inputs();
      AluValid = 1'b0; MemValid = 1'b0; IssueValid = 1'b0;
   endtask

   initial begin
      int first_grant;
      logic [AW-1:0] hold_rd;
      logic [DW-1:0] hold_wd;

      Reset = 1'b1;
      AluValid = 1'b1; MemValid = 1'b1; IssueValid = 1'b1;
      AluRD = 3'd1; MemRD = 3'd2; IssueRD = 3'd3;
      AluData = 16'h0; MemData = 16'h0;
      model_reset();
      @(posedge Clock); #1;
      check_val("rst_reg_write", RegWrite, 1'b0);
      check_val("rst_busy", Busy, 8'h00);
      check_val("rst_alu_ready", AluReady, 1'b0);
      check_val("rst_mem_ready", MemReady, 1'b0);
      check_val("rst_issue_stall", IssueStall, 1'b0);
      @(negedge Clock);
      Reset = 1'b0;
      idle_inputs();

      // single ALU request
      AluValid = 1'b1; AluRD = 3'd5; AluData = 16'h1234;
      step();
      check_val("single_we", RegWrite, 1'b1);
      check_val("single_rd", RD, 3'd5);
      check_val("single_data", WriteData, 16'h1234);
      AluValid = 1'b0;
      step();
      check_val("single_we_off", RegWrite, 1'b0);

      // conflict on the same register: Mem then ALU
      AluValid = 1'b1; AluRD = 3'd2; AluData = 16'h5555;
      MemValid = 1'b1; MemRD = 3'd2; MemData = 16'hAAAA;
      step();
      check_val("conf_first", WriteData, 16'hAAAA);
      MemValid = 1'b0;
      step();
      check_val("conf_second_we", RegWrite, 1'b1);
      check_val("conf_second", WriteData, 16'h5555);
      AluValid = 1'b0;
      step();

      // scoreboard
      IssueValid = 1'b1; IssueRD = 3'd3;
      step();
      check_val("sb_set", Busy, 8'h08);
      #1 check_val("sb_stall", IssueStall, 1'b1);
      step();
      IssueValid = 1'b0;
      MemValid = 1'b1; MemRD = 3'd3; MemData = 16'hBEEF;
      step();
      MemValid = 1'b0;
      IssueValid = 1'b1; IssueRD = 3'd3;
      step();
      check_val("sb_set_wins", Busy, 8'h08);
      IssueValid = 1'b0;
      MemValid = 1'b1; MemRD = 3'd3; MemData = 16'hCAFE;
      step();
      MemValid = 1'b0;
      step();
      check_val("sb_clear", Busy, 8'h00);

      // starvation: both held valid
      AluValid = 1'b1; AluRD = 3'd6; AluData = 16'h0606;
      MemValid = 1'b1; MemRD = 3'd7; MemData = 16'h0707;
      first_grant = 0;
      for (int i = 1; i <= 6; i++) begin
         #1;
         if (AluReady && first_grant == 0) first_grant = i;
         step();
      end
      check_val("starve_grant_cycle", first_grant, STARVE_EN ? 4 : 0);
      idle_inputs();
      step();

      // idle: outputs hold
      hold_rd = RD; hold_wd = WriteData;
      for (int i = 0; i < 10; i++) step();
      check_val("idle_rd", RD, hold_rd);
      check_val("idle_data", WriteData, hold_wd);

      // reset in the middle of a write
      IssueValid = 1'b1; IssueRD = 3'd4;
      AluValid = 1'b1; AluRD = 3'd6; AluData = 16'h9876;
      step();
      IssueValid = 1'b0;
      check_val("mid_we_before", RegWrite, 1'b1);
      #2 Reset = 1'b1;
      #1;
      check_val("mid_rst_we", RegWrite, 1'b0);
      check_val("mid_rst_rd", RD, 3'd0);
      check_val("mid_rst_data", WriteData, 16'h0);
      check_val("mid_rst_busy", Busy, 8'h00);
      check_val("mid_rst_alu_ready", AluReady, 1'b0);
      @(posedge Clock); #1;
      check_val("mid_rst_ready_hold", AluReady, 1'b0);
      @(negedge Clock);
      Reset = 1'b0;
      model_reset();
      idle_inputs();

      // randomized traffic with held requests
      for (int c = 0; c < 400; c++) begin
         if (!AluValid && $urandom_range(0, 99) < 60) begin
            AluValid = 1'b1; AluRD = AW'($urandom); AluData = DW'($urandom);
         end
         if (!MemValid && $urandom_range(0, 99) < 45) begin
            MemValid = 1'b1; MemRD = AW'($urandom); MemData = DW'($urandom);
         end
         IssueValid = ($urandom_range(0, 99) < 40);
         IssueRD = AW'($urandom);
         step();
         if (exp_ag) AluValid = 1'b0;
         if (exp_mg) MemValid = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
